// File: rtl/instr_fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcode field layout, the halt opcode
// and the fetch FSM state encoding (also used by the decode-stage bench).
package instr_fetch_stage_pkg;

  localparam int unsigned OPC_WIDTH = 4;
  localparam logic [OPC_WIDTH-1:0] OPC_HALT = 4'b1111;

  typedef enum logic [1:0] {
    FETCH   = 2'b00,
    DELIVER = 2'b01,
    HALTED  = 2'b10
  } fetch_state_e;

  function automatic logic is_halt_opc(input logic [OPC_WIDTH-1:0] opc);
    return (opc == OPC_HALT);
  endfunction

endpackage

// File: rtl/instr_fetch_stage_pc_register.sv
// Program counter: holds, increments (wrapping) or loads a redirect target.
// A load takes priority over an increment.
module instr_fetch_stage_pc_register #(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                load,
  input  logic [PC_WIDTH-1:0] load_value,
  input  logic                incr,
  output logic [PC_WIDTH-1:0] pc
);

  logic [PC_WIDTH-1:0] pc_r;

  // PC state update
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pc_r <= PC_WIDTH'(RESET_PC);
    end else if (load) begin
      pc_r <= load_value;
    end else if (incr) begin
      pc_r <= pc_r + PC_WIDTH'(1'b1);
    end else begin
      pc_r <= pc_r;
    end
  end

  assign pc = pc_r;

endmodule

// File: rtl/instr_fetch_stage.sv
// Fetch stage: one outstanding instruction-memory request at a time, latched
// instruction presented to decode with valid/stall, branch flush and halt stop.
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 16,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  output logic                   Mem_Req,
  output logic [PC_WIDTH-1:0]    Mem_Addr,
  input  logic                   Mem_Ready,
  input  logic [INSTR_WIDTH-1:0] Mem_Data,
  input  logic                   Stall,
  input  logic                   Branch_Taken,
  input  logic [PC_WIDTH-1:0]    Branch_Target,
  output logic                   Instr_Valid,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic [OPC_WIDTH-1:0]   Op_Code,
  output logic [PC_WIDTH-1:0]    Instr_PC,
  output logic                   Halted
);

  fetch_state_e            state_r;
  fetch_state_e            state_nxt_s;
  logic [PC_WIDTH-1:0]     pc_s;
  logic                    pc_load_s;
  logic                    pc_incr_s;
  logic                    capture_s;
  logic                    valid_r;
  logic                    valid_nxt_s;
  logic                    halt_pend_r;
  logic                    halt_pend_nxt_s;
  logic                    halted_r;
  logic                    halted_nxt_s;
  logic [INSTR_WIDTH-1:0]  instr_r;
  logic [PC_WIDTH-1:0]     instr_pc_r;

  instr_fetch_stage_pc_register #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .load       (pc_load_s),
    .load_value (Branch_Target),
    .incr       (pc_incr_s),
    .pc         (pc_s)
  );

  // Next-state and control decode; a redirect outranks stall and memory data
  always_comb begin
    state_nxt_s     = state_r;
    pc_load_s       = 1'b0;
    pc_incr_s       = 1'b0;
    capture_s       = 1'b0;
    valid_nxt_s     = valid_r;
    halt_pend_nxt_s = halt_pend_r;
    halted_nxt_s    = halted_r;
    case (state_r)
      FETCH: begin
        if (Branch_Taken) begin
          pc_load_s       = 1'b1;
          valid_nxt_s     = 1'b0;
          halt_pend_nxt_s = 1'b0;
          state_nxt_s     = FETCH;
        end else if (Mem_Ready) begin
          capture_s       = 1'b1;
          pc_incr_s       = 1'b1;
          valid_nxt_s     = 1'b1;
          halt_pend_nxt_s = is_halt_opc(Mem_Data[INSTR_WIDTH-1 -: OPC_WIDTH]);
          state_nxt_s     = DELIVER;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DELIVER: begin
        if (Branch_Taken) begin
          pc_load_s       = 1'b1;
          valid_nxt_s     = 1'b0;
          halt_pend_nxt_s = 1'b0;
          state_nxt_s     = FETCH;
        end else if (!Stall) begin
          valid_nxt_s = 1'b0;
          if (halt_pend_r) begin
            halted_nxt_s = 1'b1;
            state_nxt_s  = HALTED;
          end else begin
            state_nxt_s = FETCH;
          end
        end else begin
          state_nxt_s = DELIVER;
        end
      end
      HALTED: begin
        valid_nxt_s  = 1'b0;
        halted_nxt_s = 1'b1;
        state_nxt_s  = HALTED;
      end
      default: begin
        valid_nxt_s     = 1'b0;
        halt_pend_nxt_s = 1'b0;
        state_nxt_s     = FETCH;
      end
    endcase
  end

  // State and status flags
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r     <= FETCH;
      valid_r     <= 1'b0;
      halt_pend_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      valid_r     <= valid_nxt_s;
      halt_pend_r <= halt_pend_nxt_s;
      halted_r    <= halted_nxt_s;
    end
  end

  // Instruction latch; held unchanged while stalled or flushed
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      instr_r    <= {INSTR_WIDTH{1'b0}};
      instr_pc_r <= {PC_WIDTH{1'b0}};
    end else if (capture_s) begin
      instr_r    <= Mem_Data;
      instr_pc_r <= pc_s;
    end else begin
      instr_r    <= instr_r;
      instr_pc_r <= instr_pc_r;
    end
  end

  assign Mem_Req     = (state_r == FETCH);
  assign Mem_Addr    = pc_s;
  assign Instr_Valid = valid_r;
  assign Instruction = instr_r;
  assign Op_Code     = instr_r[INSTR_WIDTH-1 -: OPC_WIDTH];
  assign Instr_PC    = instr_pc_r;
  assign Halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: array-backed instruction memory,
// hand-computed expectations checked one cycle at a time.
module tb_instr_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ready;
  logic [15:0] mem_data;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [3:0]  op_code;
  logic [7:0]  instr_pc;
  logic        halted;

  logic [15:0] mem [256];
  int          n_checks;
  int          n_fails;

  assign mem_data = mem[mem_addr];

  instr_fetch_stage #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (16),
    .RESET_PC    (0)
  ) dut (
    .Clk           (clk),
    .Rst_n         (rst_n),
    .Mem_Req       (mem_req),
    .Mem_Addr      (mem_addr),
    .Mem_Ready     (mem_ready),
    .Mem_Data      (mem_data),
    .Stall         (stall),
    .Branch_Taken  (branch_taken),
    .Branch_Target (branch_target),
    .Instr_Valid   (instr_valid),
    .Instruction   (instruction),
    .Op_Code       (op_code),
    .Instr_PC      (instr_pc),
    .Halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fails       = 0;
    rst_n         = 1'b0;
    mem_ready     = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[5] = 16'hF000;

    // reset state
    #2;
    check_value("rst_valid", 32'(instr_valid), 32'd0);
    check_value("rst_instr", 32'(instruction), 32'd0);
    check_value("rst_opc",   32'(op_code),     32'd0);
    check_value("rst_ipc",   32'(instr_pc),    32'd0);
    check_value("rst_halt",  32'(halted),      32'd0);
    check_value("rst_req",   32'(mem_req),     32'd1);
    check_value("rst_addr",  32'(mem_addr),    32'd0);
    step();
    step();
    rst_n = 1'b1;

    // back-to-back fetch, one instruction every two cycles
    mem_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      check_value("seq_req_f",  32'(mem_req),  32'd1);
      check_value("seq_addr",   32'(mem_addr), 32'(n));
      step();
      check_value("seq_valid",  32'(instr_valid), 32'd1);
      check_value("seq_ipc",    32'(instr_pc),    32'(n));
      check_value("seq_opc",    32'(op_code),     32'd1);
      check_value("seq_instr",  32'(instruction), 32'h1000 + 32'(n));
      check_value("seq_req_d",  32'(mem_req),     32'd0);
      step();
    end

    // memory wait states
    mem_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      check_value("wait_req",   32'(mem_req),  32'd1);
      check_value("wait_addr",  32'(mem_addr), 32'd3);
      step();
      check_value("wait_valid", 32'(instr_valid), 32'd0);
    end
    mem_ready = 1'b1;
    check_value("wait_req4",  32'(mem_req),  32'd1);
    check_value("wait_addr4", 32'(mem_addr), 32'd3);
    step();
    mem_ready = 1'b0;
    check_value("wait_valid4", 32'(instr_valid), 32'd1);
    check_value("wait_ipc",    32'(instr_pc),    32'd3);

    // stall holds the delivered instruction
    stall = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      check_value("stall_valid", 32'(instr_valid), 32'd1);
      check_value("stall_ipc",   32'(instr_pc),    32'd3);
      check_value("stall_instr", 32'(instruction), 32'h1003);
      check_value("stall_req",   32'(mem_req),     32'd0);
    end
    stall = 1'b0;
    step();
    check_value("unstall_valid", 32'(instr_valid), 32'd0);
    check_value("unstall_req",   32'(mem_req),     32'd1);
    check_value("unstall_addr",  32'(mem_addr),    32'd4);

    // redirect overrides stall in DELIVER
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_value("br_pre_ipc", 32'(instr_pc), 32'd4);
    stall = 1'b1;
    step();
    branch_taken  = 1'b1;
    branch_target = 8'h40;
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    check_value("br_valid", 32'(instr_valid), 32'd0);
    check_value("br_req",   32'(mem_req),     32'd1);
    check_value("br_addr",  32'(mem_addr),    32'h40);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_value("br_fetch_ipc",   32'(instr_pc),    32'h40);
    check_value("br_fetch_instr", 32'(instruction), 32'h1040);
    step();
    check_value("br_next_addr", 32'(mem_addr), 32'h41);

    // redirect in FETCH discards same-cycle memory data
    branch_taken  = 1'b1;
    branch_target = 8'h05;
    mem_ready     = 1'b1;
    step();
    branch_taken = 1'b0;
    mem_ready    = 1'b0;
    check_value("brf_valid", 32'(instr_valid), 32'd0);
    check_value("brf_addr",  32'(mem_addr),    32'd5);
    check_value("brf_ipc",   32'(instr_pc),    32'h40);

    // flushed halt never halts
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_value("hflush_opc", 32'(op_code),  32'hF);
    check_value("hflush_ipc", 32'(instr_pc), 32'd5);
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 8'h10;
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    check_value("hflush_halt",  32'(halted),   32'd0);
    check_value("hflush_addr",  32'(mem_addr), 32'h10);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_value("hflush_instr", 32'(instruction), 32'h1010);
    step();
    check_value("hflush_halt2", 32'(halted),   32'd0);
    check_value("hflush_req",   32'(mem_req),  32'd1);
    check_value("hflush_addr2", 32'(mem_addr), 32'h11);

    // consumed halt stops the stage
    branch_taken  = 1'b1;
    branch_target = 8'h05;
    step();
    branch_taken = 1'b0;
    mem_ready    = 1'b1;
    step();
    mem_ready = 1'b0;
    check_value("halt_opc",   32'(op_code),     32'hF);
    check_value("halt_valid", 32'(instr_valid), 32'd1);
    check_value("halt_early", 32'(halted),      32'd0);
    step();
    check_value("halt_flag",  32'(halted),      32'd1);
    check_value("halt_req",   32'(mem_req),     32'd0);
    check_value("halt_vld0",  32'(instr_valid), 32'd0);
    branch_taken  = 1'b1;
    branch_target = 8'h20;
    mem_ready     = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      check_value("halt_hold",  32'(halted),      32'd1);
      check_value("halt_noreq", 32'(mem_req),     32'd0);
      check_value("halt_novld", 32'(instr_valid), 32'd0);
      check_value("halt_pc",    32'(mem_addr),    32'd6);
    end
    branch_taken = 1'b0;
    mem_ready    = 1'b0;

    // only reset leaves HALTED
    rst_n = 1'b0;
    #1;
    check_value("hrst_halt", 32'(halted),   32'd0);
    check_value("hrst_req",  32'(mem_req),  32'd1);
    check_value("hrst_addr", 32'(mem_addr), 32'd0);
    step();
    rst_n = 1'b1;

    // PC wrap at 8'hFF
    branch_taken  = 1'b1;
    branch_target = 8'hFF;
    step();
    branch_taken = 1'b0;
    check_value("wrap_addr_ff", 32'(mem_addr), 32'hFF);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_value("wrap_ipc",   32'(instr_pc),    32'hFF);
    check_value("wrap_instr", 32'(instruction), 32'h10FF);
    step();
    check_value("wrap_addr0", 32'(mem_addr), 32'h00);
    check_value("wrap_req",   32'(mem_req),  32'd1);

    // asynchronous reset mid-delivery
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    stall     = 1'b1;
    check_value("arst_pre_valid", 32'(instr_valid), 32'd1);
    check_value("arst_pre_addr",  32'(mem_addr),    32'd1);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check_value("arst_valid", 32'(instr_valid), 32'd0);
    check_value("arst_instr", 32'(instruction), 32'd0);
    check_value("arst_opc",   32'(op_code),     32'd0);
    check_value("arst_ipc",   32'(instr_pc),    32'd0);
    check_value("arst_halt",  32'(halted),      32'd0);
    check_value("arst_req",   32'(mem_req),     32'd1);
    check_value("arst_addr",  32'(mem_addr),    32'd0);
    stall = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
